// File: rtl/mic_fifo_drain_sched_if.sv
// mic_fifo_drain_sched_if: FIFO-bank and PHY transmit signals of the drain scheduler
interface mic_fifo_drain_sched_if #(parameter int NUM_FIFO = 4);
    logic [NUM_FIFO-1:0]   full_en;
    logic [8*NUM_FIFO-1:0] fifo_data;
    logic [NUM_FIFO-1:0]   fifo_enable;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_sof;
    logic                  tx_eof;
    modport master (
        input  full_en, fifo_data,
        output fifo_enable, tx_valid, tx_data, tx_sof, tx_eof
    );
    modport slave (
        output full_en, fifo_data,
        input  fifo_enable, tx_valid, tx_data, tx_sof, tx_eof
    );
endinterface

// File: rtl/mic_fifo_drain_sched.sv
// mic_fifo_drain_sched: round-robin FIFO drain scheduler with framed tx stream; DRAIN_CHECKSUM_EN appends an XOR checksum byte
module mic_fifo_drain_sched #(
    parameter int NUM_FIFO   = 4,
    parameter int BURST_LEN  = 1200,
    parameter int GAP_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mic_fifo_drain_sched_if.master       bus,
    output logic                         busy_o,
    output logic [15:0]                  frame_count_o
);
    typedef enum logic [1:0] {IDLE, BURST, FLUSH, GAP} state_t;
    localparam logic [15:0] BL1 = 16'(BURST_LEN - 1);
    localparam logic [15:0] GP1 = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  g_q, g_d, rr_q, rr_d, pick_lo, pick_hi;
    logic        hit_hi;
    logic        en_q, lst_q, hdr, lst;
    logic        tx_valid_q, tx_valid_d, tx_sof_q, tx_eof_q, tx_eof_d;
    logic [7:0]  tx_data_q, tx_data_d, byte_in;
    logic [15:0] frame_count_q;
`ifdef DRAIN_CHECKSUM_EN
    logic        pend_q;
    logic [7:0]  csum_q, csum_d;
`endif
    // Lowest requester at/above rr_q wins; otherwise wrap to lowest overall.
    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        hit_hi  = 1'b0;
        for (int i = NUM_FIFO - 1; i >= 0; i--) begin
            if (bus.full_en[i]) pick_lo = 4'(i);
            if (bus.full_en[i] && 4'(i) >= rr_q) begin
                pick_hi = 4'(i);
                hit_hi  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        unique case (state_q)
            IDLE:  if (|bus.full_en) begin
                       state_d = BURST;
                       g_d     = hit_hi ? pick_hi : pick_lo;
                   end
            BURST: if (cnt_q == BL1) state_d = FLUSH;
            FLUSH: if (tx_eof_q) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (cnt_q == GP1) state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;
        rr_d  = (state_q != FLUSH) ? rr_q : (g_q == 4'(NUM_FIFO - 1)) ? 4'd0 : g_q + 4'd1;
    end
    always_comb begin
        bus.fifo_enable = (state_q == BURST) ? NUM_FIFO'(1) << g_q : '0;
        busy_o          = state_q != IDLE;
    end
    // en_q marks cycles where fifo_data carries a payload byte (1-cycle read latency).
    always_comb begin
        hdr     = (state_q == BURST) && (cnt_q == '0);
        lst     = (state_q == BURST) && (cnt_q == BL1);
        byte_in = '0;
        for (int i = 0; i < NUM_FIFO; i++)
            if (g_q == 4'(i)) byte_in = bus.fifo_data[8*i +: 8];
`ifdef DRAIN_CHECKSUM_EN
        tx_valid_d = hdr | en_q | pend_q;
        tx_data_d  = hdr ? {4'hA, g_q} : pend_q ? csum_q : byte_in;
        tx_eof_d   = pend_q;
        csum_d     = hdr ? {4'hA, g_q} : en_q ? csum_q ^ byte_in : csum_q;
`else
        tx_valid_d = hdr | en_q;
        tx_data_d  = hdr ? {4'hA, g_q} : byte_in;
        tx_eof_d   = lst_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            lst_q         <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_sof_q      <= 1'b0;
            tx_eof_q      <= 1'b0;
            frame_count_q <= '0;
`ifdef DRAIN_CHECKSUM_EN
            pend_q        <= 1'b0;
            csum_q        <= '0;
`endif
        end else begin
            en_q          <= state_q == BURST;
            lst_q         <= lst;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_valid_d ? tx_data_d : '0;
            tx_sof_q      <= hdr;
            tx_eof_q      <= tx_eof_d;
            frame_count_q <= tx_eof_q ? frame_count_q + 16'd1 : frame_count_q;
`ifdef DRAIN_CHECKSUM_EN
            pend_q        <= lst_q;
            csum_q        <= csum_d;
`endif
        end
    end
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_sof    = tx_sof_q;
    assign bus.tx_eof    = tx_eof_q;
    assign frame_count_o = frame_count_q;
endmodule

// File: tb/tb_mic_fifo_drain_sched.sv
// tb_mic_fifo_drain_sched: directed checks of grants, frame bytes, timing, reset and frame-count wrap
module tb_mic_fifo_drain_sched;
    localparam int NF = 4, BL = 4, GP = 2;
`ifdef DRAIN_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    mic_fifo_drain_sched_if #(.NUM_FIFO(NF)) bus ();
    logic        busy;
    logic [15:0] frame_count;
    mic_fifo_drain_sched #(.NUM_FIFO(NF), .BURST_LEN(BL), .GAP_CYCLES(GP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .frame_count_o(frame_count)
    );
    int n_run = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [9:0]    txq[$];
    int            gnt_i[$], gnt_c[$];
    int            sof_c = 0, idle_c = 0, eof_n = 0, run = 0, max_run = 0;
    logic [NF-1:0] prev_en = '0;
    logic          prev_busy = 1'b0;
    initial forever begin
        @(negedge clk);
        if (bus.tx_valid) txq.push_back({bus.tx_sof, bus.tx_eof, bus.tx_data});
        if (bus.tx_valid && bus.tx_sof) sof_c = cyc;
        if (bus.tx_eof) eof_n++;
        if (bus.fifo_enable != '0 && bus.fifo_enable != prev_en) begin
            for (int i = 0; i < NF; i++) if (bus.fifo_enable[i]) gnt_i.push_back(i);
            gnt_c.push_back(cyc);
        end
        run = (bus.fifo_enable == '0) ? 0 : (bus.fifo_enable == prev_en) ? run + 1 : 1;
        if (run > max_run) max_run = run;
        if (prev_busy && !busy) idle_c = cyc;
        prev_en   = bus.fifo_enable;
        prev_busy = busy;
    end
    logic [1:0]    ctr[NF];
    logic [NF-1:0] en_s;
    initial begin
        bus.fifo_data = '0;
        for (int i = 0; i < NF; i++) ctr[i] = '0;
        forever begin
            @(negedge clk);
            en_s = bus.fifo_enable;
            @(posedge clk);
            #1;
            for (int i = 0; i < NF; i++)
                if (en_s[i]) begin
                    bus.fifo_data[8*i +: 8] = 8'h11 * (8'(ctr[i]) + 8'd1);
                    ctr[i]++;
                end
        end
    end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_en(input string tag);
        int t = 0;
        while (bus.fifo_enable == '0 && t < 100) begin tick(); t++; end
        chk(tag, 32'(bus.fifo_enable != '0), 1);
    endtask
    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 200) begin tick(); t++; end
        chk(tag, 32'(busy), 0);
    endtask
    task automatic check_frame(input logic [3:0] g);
        logic [7:0] e[6];
        e[0] = {4'hA, g};
        e[1] = 8'h11; e[2] = 8'h22; e[3] = 8'h33; e[4] = 8'h44;
        e[5] = e[0] ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
        chk("frame_len", txq.size(), 5 + CK);
        for (int k = 0; k < 5 + CK && k < txq.size(); k++) begin
            chk($sformatf("byte%0d", k), 32'(txq[k][7:0]), 32'(e[k]));
            chk($sformatf("sof%0d", k), 32'(txq[k][9]), 32'(k == 0));
            chk($sformatf("eof%0d", k), 32'(txq[k][8]), 32'(k == 4 + CK));
        end
    endtask
    int t, eof0;
    initial begin
        bus.full_en = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("idle_en", 32'(bus.fifo_enable), 0);
        chk("idle_valid", 32'(bus.tx_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_frames", 32'(frame_count), 0);
        chk("idle_txcount", txq.size(), 0);
        bus.full_en = 4'b0100;
        wait_en("t2_grant");
        bus.full_en = '0;
        chk("t2_en", 32'(bus.fifo_enable), 32'h4);
        wait_idle("t2_idle");
        tick(); tick();
        check_frame(4'd2);
        chk("t2_sof_lat", sof_c - gnt_c[$], 1);
        chk("t2_idle_lat", idle_c - gnt_c[$], BL + 2 + GP + CK);
        chk("t2_frames", 32'(frame_count), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        txq.delete(); gnt_i.delete(); gnt_c.delete();
        max_run = 0;
        bus.full_en = 4'b1011;
        t = 0;
        while (gnt_i.size() < 4 && t < 300) begin tick(); t++; end
        bus.full_en = '0;
        chk("t3_grants", 32'(gnt_i.size() >= 4), 1);
        for (int k = 0; k < 4 && k < gnt_i.size(); k++)
            chk($sformatf("t3_order%0d", k), gnt_i[k], (k == 2) ? 3 : (k == 1) ? 1 : 0);
        wait_idle("t3_idle");
        chk("t3_max_run", max_run, BL);
        eof0 = eof_n;
        bus.full_en = 4'b0010;
        wait_en("t4_grant");
        bus.full_en = '0;
        tick(); tick();
        chk("t4_burst3", 32'(bus.fifo_enable), 32'h2);
        rst_n = 1'b0;
        tick();
        chk("t4_rst_en", 32'(bus.fifo_enable), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_valid", 32'(bus.tx_valid), 0);
        chk("t4_rst_frames", 32'(frame_count), 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t4_no_eof", eof_n - eof0, 0);
        bus.full_en = 4'b0011;
        wait_en("t4_rr_grant");
        bus.full_en = '0;
        chk("t4_rr_zero", 32'(bus.fifo_enable), 32'h1);
        wait_idle("t4_idle");
        chk("t4_frames", 32'(frame_count), 1);
        txq.delete();
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        chk("t5_preload", 32'(frame_count), 32'hFFFF);
        bus.full_en = 4'b0100;
        wait_en("t5_grant");
        bus.full_en = '0;
        wait_idle("t5_idle");
        tick(); tick();
        check_frame(4'd2);
        chk("t5_wrap", 32'(frame_count), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
